// File: rtl/hs_pipe_slice.sv
// Chain of DEPTH registered valid/ready slices, each a main register plus a skid register,
// with synchronous flush and a registered occupancy count.
module hs_pipe_slice #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(2 * DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_up_in,
  output logic             ready_up_out,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_down_out,
  input  logic             ready_down_in,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [DEPTH-1:0] st_main_v;
  logic [DEPTH-1:0] st_skid_v;
  logic [DEPTH-1:0] st_in_v;
  logic [DEPTH-1:0] st_out_rdy;
  logic [WIDTH-1:0] st_main_data [DEPTH];
  logic [WIDTH-1:0] st_in_data   [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             main_v_q, main_v_d;
    logic             skid_v_q, skid_v_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             in_fire;

    if (k == 0) begin : g_first
      assign st_in_v[k]    = valid_up_in;
      assign st_in_data[k] = data_in;
    end else begin : g_chain
      assign st_in_v[k]    = st_main_v[k-1];
      assign st_in_data[k] = st_main_data[k-1];
    end

    if (k == DEPTH - 1) begin : g_last
      assign st_out_rdy[k] = ready_down_in;
    end else begin : g_inner
      assign st_out_rdy[k] = ~st_skid_v[k+1];
    end

    // Ready toward the producer depends only on our own skid flag, never on downstream ready.
    assign in_fire = st_in_v[k] & ~skid_v_q;

    always_comb begin
      main_v_d    = main_v_q;
      main_data_d = main_data_q;
      skid_v_d    = skid_v_q;
      skid_data_d = skid_data_q;
      if (st_out_rdy[k] || !main_v_q) begin
        if (skid_v_q) begin
          main_v_d    = 1'b1;
          main_data_d = skid_data_q;
          skid_v_d    = 1'b0;
        end else begin
          main_v_d = in_fire;
          if (in_fire) begin
            main_data_d = st_in_data[k];
          end
        end
      end else if (in_fire) begin
        skid_v_d    = 1'b1;
        skid_data_d = st_in_data[k];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        main_v_q    <= 1'b0;
        skid_v_q    <= 1'b0;
        main_data_q <= '0;
        skid_data_q <= '0;
      end else if (flush) begin
        main_v_q <= 1'b0;
        skid_v_q <= 1'b0;
      end else begin
        main_v_q    <= main_v_d;
        skid_v_q    <= skid_v_d;
        main_data_q <= main_data_d;
        skid_data_q <= skid_data_d;
      end
    end

    assign st_main_v[k]    = main_v_q;
    assign st_skid_v[k]    = skid_v_q;
    assign st_main_data[k] = main_data_q;
  end

  assign ready_up_out   = ~st_skid_v[0];
  assign valid_down_out = st_main_v[DEPTH-1];
  assign data_out       = st_main_data[DEPTH-1];

  logic          up_fire, down_fire;
  logic [CW-1:0] count_q, count_d;

  assign up_fire   = valid_up_in & ready_up_out;
  assign down_fire = valid_down_out & ready_down_in;

  always_comb begin
    count_d = count_q;
    if (up_fire && !down_fire) begin
      count_d = count_q + CW'(1);
    end else if (down_fire && !up_fire) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: tb/tb_hs_pipe_slice.sv
// Randomised and directed bench for hs_pipe_slice against a queue-based FIFO model.
module tb_hs_pipe_slice;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CAP   = 2 * DEPTH;
  localparam int unsigned CW    = $clog2(2 * DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             flush;
  logic [WIDTH-1:0] data_in;
  logic             valid_up_in;
  logic             ready_up_out;
  logic [WIDTH-1:0] data_out;
  logic             valid_down_out;
  logic             ready_down_in;
  logic [CW-1:0]    count;
  logic             empty;

  hs_pipe_slice #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .data_in       (data_in),
    .valid_up_in   (valid_up_in),
    .ready_up_out  (ready_up_out),
    .data_out      (data_out),
    .valid_down_out(valid_down_out),
    .ready_down_in (ready_down_in),
    .count         (count),
    .empty         (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int edge_cnt = 0;
  bit chk_lat  = 1'b0;
  bit last_up_fire;

  logic [WIDTH-1:0] model_q[$];
  int               lat_q[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Drive one cycle's inputs at a falling edge, update the model, and check at the next one.
  task automatic cycle(input logic vu, input logic [WIDTH-1:0] d, input logic rd,
                       input logic fl, input logic rs);
    logic             uf, df, stall;
    logic [WIDTH-1:0] hold;
    int               acc_edge;
    valid_up_in   = vu;
    data_in       = d;
    ready_down_in = rd;
    flush         = fl;
    rst           = rs;
    uf    = vu & ready_up_out;
    df    = valid_down_out & rd;
    stall = valid_down_out & ~rd & ~fl & ~rs;
    hold  = data_out;
    last_up_fire = uf & ~fl & ~rs;
    if (rs || fl) begin
      model_q.delete();
      lat_q.delete();
    end else begin
      if (df) begin
        if (model_q.size() == 0) begin
          check("dn_spurious", 1, 0);
        end else begin
          check("dn_data", data_out, model_q.pop_front());
          acc_edge = lat_q.pop_front();
          if (chk_lat) check("latency", edge_cnt - acc_edge, DEPTH);
        end
      end
      if (uf) begin
        model_q.push_back(d);
        lat_q.push_back(edge_cnt);
      end
    end
    @(posedge clk);
    edge_cnt++;
    @(negedge clk);
    check("count", count, model_q.size());
    check("empty", empty, model_q.size() == 0);
    check("cnt_max", count <= CAP, 1);
    if (stall) begin
      check("hold_v", valid_down_out, 1);
      check("hold_d", data_out, hold);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_vdown"}, valid_down_out, 0);
    check({tag, "_rup"}, ready_up_out, 1);
    check({tag, "_dout"}, data_out, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_empty"}, empty, 1);
  endtask

  initial begin
    int n;
    int cyc;
    rst = 1'b1;
    flush = 1'b0;
    valid_up_in = 1'b0;
    data_in = '0;
    ready_down_in = 1'b0;
    @(negedge clk);

    // Reset held two cycles
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_reset_outs("rst");

    // Streaming 0x01..0x10 with ready held high
    chk_lat = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 16 && cyc < 100) begin
      cycle(1'b1, 8'(n + 1), 1'b1, 1'b0, 1'b0);
      if (last_up_fire) n++;
      cyc++;
    end
    check("stream_accepts", n, 16);
    check("stream_no_bubble", cyc, 16);
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("stream_drained", model_q.size(), 0);
    chk_lat = 1'b0;

    // Full backpressure
    n = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 8'(8'hA0 + n), 1'b0, 1'b0, 1'b0);
      if (last_up_fire) n++;
      if (n >= int'(CAP)) check("bp_ready", ready_up_out, 0);
    end
    check("bp_accepts", n, CAP);
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("bp_drained", model_q.size(), 0);

    // Random valid/ready, 1000 words
    n = 0;
    cyc = 0;
    while (n < 1000 && cyc < 20000) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (last_up_fire) n++;
      cyc++;
    end
    check("rand_budget", n, 1000);
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("rand_drained", model_q.size(), 0);

    // Flush with 3 stored and a concurrent up_fire
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    check("fl_pre_count", count, 3);
    check("fl_pre_rup", ready_up_out, 1);
    cycle(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
    check("fl_count", count, 0);
    check("fl_vdown", valid_down_out, 0);
    check("fl_rup", ready_up_out, 1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Reset mid-operation with 4 stored
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    check("mr_pre_count", count, CAP);
    cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
    check_reset_outs("mr");
    chk_lat = 1'b1;
    cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    check("mr_accept", last_up_fire, 1);
    check("mr_not_yet", valid_down_out, 0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("mr_vdown", valid_down_out, 1);
    check("mr_dout", data_out, 8'h55);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("mr_drained", model_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
